// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_seq_pkg;

    localparam int unsigned ADDR_W = 16;

    // All-zero instruction word (NOP); also the post-reset redirect address.
    localparam logic [ADDR_W-1:0] ZERO_INSTR = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fs_state_e;

endpackage : fetch_seq_pkg

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter with synchronous clear.
module sat_counter16 (
    input  logic        clk,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: hold at the ceiling instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != SAT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter16

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: turns redirects, load-use hazards and halt/resume
// into PC-mux, stall and flush controls for the program-memory stage.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              load_use,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jump_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic              flush,
    output logic              fetch_valid,
    output logic [1:0]        fsm_state,
    output logic [15:0]       redirect_count,
    output logic [15:0]       stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    fs_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_target_q, last_target_d;
    logic              redirect_inc;

    // Next-state and same-cycle (Mealy) fetch controls.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_target_d = last_target_q;
        redirect_inc  = 1'b0;
        pc_mux_sel    = 1'b0;
        stall         = 1'b0;
        stall_pm      = 1'b0;
        flush         = 1'b0;
        fetch_valid   = 1'b0;

        unique case (state_q)
            ST_RUN, ST_STALL: begin
                if (branch_req) begin
                    // Redirect: steer the PC now and squash wrong-path slots.
                    pc_mux_sel    = 1'b1;
                    flush         = 1'b1;
                    last_target_d = branch_target;
                    redirect_inc  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_STALL) begin
                    stall    = 1'b1;
                    stall_pm = 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else if (halt_req) begin
                    stall    = 1'b1;
                    stall_pm = 1'b1;
                    state_d  = ST_HALT;
                end else if (load_use) begin
                    stall    = 1'b1;
                    stall_pm = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        cnt_d   = STALL_LOAD;
                        state_d = ST_STALL;
                    end
                end else begin
                    fetch_valid = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Requests here come from wrong-path instructions.
                flush = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HALT: begin
                // Stay stalled through the resume cycle itself.
                stall    = 1'b1;
                stall_pm = 1'b1;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (reset) begin
            pc_mux_sel   = 1'b0;
            stall        = 1'b0;
            stall_pm     = 1'b0;
            flush        = 1'b1;
            fetch_valid  = 1'b0;
            redirect_inc = 1'b0;
        end

        jump_loc = pc_mux_sel ? branch_target : last_target_q;
    end

    // Sequencer state, down-counter and last redirect address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            last_target_q <= ZERO_INSTR;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_target_q <= last_target_d;
        end
    end

    assign fsm_state = 2'(state_q);

    sat_counter16 u_redirect_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (redirect_inc),
        .count_o (redirect_count)
    );

    sat_counter16 u_stall_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (stall),
        .count_o (stall_count)
    );

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed cycles push expected
// outputs, a negedge monitor pops and compares them.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br = 1'b0, lu = 1'b0, hr = 1'b0, rs = 1'b0;
    logic [15:0] tgt = 16'h0;
    logic        br_b = 1'b0;
    logic [15:0] tgt_b = 16'hBEEF;

    logic        a_pc, a_st, a_spm, a_fl, a_fv;
    logic [15:0] a_jl, a_rc, a_sc;
    logic [1:0]  a_fsm;
    logic        b_pc, b_st, b_spm, b_fl, b_fv;
    logic [15:0] b_jl, b_rc, b_sc;
    logic [1:0]  b_fsm;

    typedef struct packed {
        logic        is_b;
        logic        pc;
        logic [15:0] jl;
        logic        st;
        logic        spm;
        logic        fl;
        logic        fv;
        logic [1:0]  fsm;
        logic [15:0] rc;
        logic [15:0] sc;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .branch_req(br), .branch_target(tgt),
        .load_use(lu), .halt_req(hr), .resume(rs),
        .pc_mux_sel(a_pc), .jump_loc(a_jl), .stall(a_st), .stall_pm(a_spm),
        .flush(a_fl), .fetch_valid(a_fv), .fsm_state(a_fsm),
        .redirect_count(a_rc), .stall_count(a_sc)
    );

    fetch_sequencer #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .branch_req(br_b), .branch_target(tgt_b),
        .load_use(1'b0), .halt_req(1'b0), .resume(1'b0),
        .pc_mux_sel(b_pc), .jump_loc(b_jl), .stall(b_st), .stall_pm(b_spm),
        .flush(b_fl), .fetch_valid(b_fv), .fsm_state(b_fsm),
        .redirect_count(b_rc), .stall_count(b_sc)
    );

    task automatic drv(input logic r, input logic b, input logic [15:0] t,
                       input logic l, input logic h, input logic s);
        @(posedge clk);
        #1;
        reset = r; br = b; tgt = t; lu = l; hr = h; rs = s;
    endtask

    task automatic push(input logic is_b, input logic pc, input logic [15:0] jl,
                        input logic st, input logic spm, input logic fl,
                        input logic fv, input logic [1:0] fsm,
                        input logic [15:0] rc, input logic [15:0] sc);
        obs_t e;
        e = '{is_b: is_b, pc: pc, jl: jl, st: st, spm: spm, fl: fl, fv: fv,
              fsm: fsm, rc: rc, sc: sc};
        exp_q.push_back(e);
    endtask

    task automatic ex(input logic pc, input logic [15:0] jl, input logic st,
                      input logic spm, input logic fl, input logic fv,
                      input logic [1:0] fsm, input logic [15:0] rc,
                      input logic [15:0] sc);
        push(1'b0, pc, jl, st, spm, fl, fv, fsm, rc, sc);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_b)
                g = '{is_b: 1'b1, pc: b_pc, jl: b_jl, st: b_st, spm: b_spm,
                      fl: b_fl, fv: b_fv, fsm: b_fsm, rc: b_rc, sc: b_sc};
            else
                g = '{is_b: 1'b0, pc: a_pc, jl: a_jl, st: a_st, spm: a_spm,
                      fl: a_fl, fv: a_fv, fsm: a_fsm, rc: a_rc, sc: a_sc};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL chk%0d dut=%s got pc=%b jl=%h st=%b spm=%b fl=%b fv=%b fsm=%0d rc=%h sc=%h | required pc=%b jl=%h st=%b spm=%b fl=%b fv=%b fsm=%0d rc=%h sc=%h",
                         n_tests, e.is_b ? "b" : "a",
                         g.pc, g.jl, g.st, g.spm, g.fl, g.fv, g.fsm, g.rc, g.sc,
                         e.pc, e.jl, e.st, e.spm, e.fl, e.fv, e.fsm, e.rc, e.sc);
            end
        end
    end

    initial begin
        // Reset held three cycles: flush forced, everything else quiet.
        repeat (3) begin drv(1,0,16'h0,0,0,0); ex(0,16'h0000,0,0,1,0,0,16'd0,16'd0); end
        repeat (2) begin drv(0,0,16'h0,0,0,0); ex(0,16'h0000,0,0,0,1,0,16'd0,16'd0); end

        // Load-use: three stalled cycles.
        drv(0,0,16'h0,1,0,0); ex(0,16'h0000,1,1,0,0,0,16'd0,16'd0);
        drv(0,0,16'h0,0,0,0); ex(0,16'h0000,1,1,0,0,1,16'd0,16'd1);
        drv(0,0,16'h0,0,0,0); ex(0,16'h0000,1,1,0,0,1,16'd0,16'd2);
        drv(0,0,16'h0,0,0,0); ex(0,16'h0000,0,0,0,1,0,16'd0,16'd3);

        // Redirect to 0x0040; requests during FLUSH are ignored.
        drv(0,1,16'h0040,0,0,0); ex(1,16'h0040,0,0,1,0,0,16'd0,16'd3);
        drv(0,1,16'h1234,1,1,0); ex(0,16'h0040,0,0,1,0,2,16'd1,16'd3);
        drv(0,0,16'h0,0,0,0);    ex(0,16'h0040,0,0,0,1,0,16'd1,16'd3);

        // Branch during the second stall cycle aborts the stall.
        drv(0,0,16'h0,1,0,0);    ex(0,16'h0040,1,1,0,0,0,16'd1,16'd3);
        drv(0,1,16'h0100,0,0,0); ex(1,16'h0100,0,0,1,0,1,16'd1,16'd4);
        drv(0,0,16'h0,0,0,0);    ex(0,16'h0100,0,0,1,0,2,16'd2,16'd4);
        drv(0,0,16'h0,0,0,0);    ex(0,16'h0100,0,0,0,1,0,16'd2,16'd4);

        // Halt, nine waiting cycles (branch/load-use ignored), resume.
        drv(0,0,16'h0,0,1,0); ex(0,16'h0100,1,1,0,0,0,16'd2,16'd4);
        for (int i = 0; i < 9; i++) begin
            drv(0, (i == 2), 16'h0BAD, (i == 5), 0, 0);
            ex(0,16'h0100,1,1,0,0,3,16'd2,16'(5 + i));
        end
        drv(0,0,16'h0,0,0,1); ex(0,16'h0100,1,1,0,0,3,16'd2,16'd14);
        drv(0,0,16'h0,0,0,0); ex(0,16'h0100,0,0,0,1,0,16'd2,16'd15);

        // Reset mid-FLUSH (cnt=1) clears everything.
        drv(0,1,16'h0200,0,0,0); ex(1,16'h0200,0,0,1,0,0,16'd2,16'd15);
        drv(1,0,16'h0,0,0,0);    ex(0,16'h0200,0,0,1,0,2,16'd3,16'd15);
        drv(0,0,16'h0,0,0,0);    ex(0,16'h0000,0,0,0,1,0,16'd0,16'd0);

        // Priority: branch beats halt and load-use; halt beats load-use.
        drv(0,1,16'h0300,1,1,0); ex(1,16'h0300,0,0,1,0,0,16'd0,16'd0);
        drv(0,0,16'h0,0,0,0);    ex(0,16'h0300,0,0,1,0,2,16'd1,16'd0);
        drv(0,0,16'h0,0,0,0);    ex(0,16'h0300,0,0,0,1,0,16'd1,16'd0);
        drv(0,0,16'h0,1,1,0);    ex(0,16'h0300,1,1,0,0,0,16'd1,16'd0);
        drv(0,0,16'h0,0,0,1);    ex(0,16'h0300,1,1,0,0,3,16'd1,16'd1);
        drv(0,0,16'h0,0,0,0);    ex(0,16'h0300,0,0,0,1,0,16'd1,16'd2);

        // Reset mid-STALL aborts the stall.
        drv(0,0,16'h0,1,0,0); ex(0,16'h0300,1,1,0,0,0,16'd1,16'd2);
        drv(1,0,16'h0,0,0,0); ex(0,16'h0300,0,0,1,0,1,16'd1,16'd3);
        drv(0,0,16'h0,0,0,0); ex(0,16'h0000,0,0,0,1,0,16'd0,16'd0);

        // Single-slot-flush instance: 70000 back-to-back redirects saturate.
        for (int i = 1; i <= 70000; i++) begin
            @(posedge clk);
            #1;
            br_b = 1'b1;
            if (i == 1)     push(1,1,16'hBEEF,0,0,1,0,0,16'h0000,16'h0000);
            if (i == 65535) push(1,1,16'hBEEF,0,0,1,0,0,16'hFFFE,16'h0000);
            if (i == 65536) push(1,1,16'hBEEF,0,0,1,0,0,16'hFFFF,16'h0000);
            if (i == 70000) push(1,1,16'hBEEF,0,0,1,0,0,16'hFFFF,16'h0000);
        end
        @(posedge clk);
        #1;
        br_b = 1'b0;
        push(1,0,16'hBEEF,0,0,0,1,0,16'hFFFF,16'h0000);

        repeat (2) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending entries, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_sequencer
